// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: FSM state encoding,
// the PC that word 0 of instruction memory corresponds to, and the header
// length in bytes.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam int          HDR_BYTES = 4;

    // Word index in instruction memory for a given PC.
    function automatic logic [31:0] im_index(input logic [31:0] pc);
        return (pc - IM_BASE) >> 2;
    endfunction

endpackage

// File: rtl/imem_loader_assembler.sv
// imem_loader_assembler
// Packs a big-endian byte stream into 32-bit words. The first byte of each
// 4-byte group lands in bits [31:24].
// Ports:
//   clk, reset   clock, async active-low reset
//   clear        synchronous clear of the byte counter and shift register
//   byte_en      a byte transfers this cycle
//   in_data      stream byte
//   word_valid   combinational: this transfer completes a word
//   word         the completed word (valid with word_valid)
module imem_loader_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    // Only the three earlier bytes of a word need storing; the fourth is
    // taken straight from in_data when the word completes.
    logic [23:0] shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= 2'd0;
            shift_q  <= 24'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            shift_q  <= 24'd0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= {shift_q[15:0], in_data};
        end
    end

    assign word_valid = byte_en && (byte_cnt == 2'(HDR_BYTES - 1));
    assign word       = {shift_q, in_data};

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Receives a program image as a byte stream (4-byte header N, then N words),
// writes the words into instruction memory starting at index 0 (PC 0x3000),
// and holds the CPU in reset until the image is complete.
// Ports:
//   clk, reset          clock, async active-low reset
//   in_data/in_valid    byte stream in, in_ready back-pressure out
//   restart             pulse that re-arms the loader from DONE or ERR
//   im_we/im_addr/im_wdata  instruction-memory write port
//   cpu_hold            1 keeps the core in reset
//   done / err          image loaded / header word count too large
//   words_loaded        words written since the last re-arm
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_LOG2 = 11,
    parameter int CNT_W      = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  im_we,
    output logic [DEPTH_LOG2-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [CNT_W-1:0]      words_loaded
);

    localparam logic [31:0] DEPTH_WORDS = 32'd1 << DEPTH_LOG2;

    state_t           state;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] word_total;
    logic             xfer;
    logic             rearm;
    logic             word_valid;
    logic [31:0]      word;

    assign xfer  = in_valid && in_ready;
    assign rearm = restart && ((state == ST_DONE) || (state == ST_ERR));

    imem_loader_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (rearm),
        .byte_en    (xfer),
        .in_data    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            word_idx   <= '0;
            word_total <= '0;
            in_ready   <= 1'b1;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) state <= ST_HDR;
                end
                ST_HDR: begin
                    if (word_valid) begin
                        // Range check uses the full 32-bit header so a huge N
                        // cannot alias to a small one.
                        if (word == 32'd0) begin
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (word > DEPTH_WORDS) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            word_total <= word[CNT_W-1:0];
                            state      <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        im_we    <= 1'b1;
                        im_addr  <= word_idx[DEPTH_LOG2-1:0];
                        im_wdata <= word;
                        word_idx <= word_idx + CNT_W'(1);
                        if (word_idx == word_total - CNT_W'(1)) begin
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (restart) begin
                        state      <= ST_IDLE;
                        word_idx   <= '0;
                        word_total <= '0;
                        in_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign words_loaded = word_idx;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH_LOG2 = 11;
    localparam int CNT_W      = 12;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  restart;
    logic                  im_we;
    logic [DEPTH_LOG2-1:0] im_addr;
    logic [31:0]           im_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;
    logic [CNT_W-1:0]      words_loaded;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    imem_loader #(.DEPTH_LOG2(DEPTH_LOG2), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .restart      (restart),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reset && im_we) we_count <= we_count + 1;

    // All tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %b exp 1", cpu_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (words_loaded !== 12'd0) begin errors++; $display("FAIL reset_words got %0d exp 0", words_loaded); end
        checks++; if (im_addr !== 11'd0 || im_wdata !== 32'd0) begin errors++; $display("FAIL reset_port got %h/%h exp 0/0", im_addr, im_wdata); end
        repeat (5) @(negedge clk);
        checks++; if (we_count !== 0) begin errors++; $display("FAIL reset_no_we got %0d exp 0", we_count); end
    endtask

    task automatic test_basic();
        int base;
        base = we_count;
        send_word(32'h0000_0002);
        checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_hdr got rdy=%b done=%b exp 1/0", in_ready, done); end
        send_word(32'h3408_0005);
        checks++; if (im_we !== 1'b1 || im_addr !== 11'd0 || im_wdata !== 32'h3408_0005) begin errors++; $display("FAIL basic_w0 got we=%b a=%h d=%h exp 1/000/34080005", im_we, im_addr, im_wdata); end
        checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 12'd1) begin errors++; $display("FAIL basic_w0_status got done=%b hold=%b n=%0d exp 0/1/1", done, cpu_hold, words_loaded); end
        // first byte of word 1 goes in during the write-pulse cycle
        send_word(32'h0000_000C);
        checks++; if (im_we !== 1'b1 || im_addr !== 11'(im_index(32'h3004)) || im_wdata !== 32'h0000_000C) begin errors++; $display("FAIL basic_w1 got we=%b a=%h d=%h exp 1/001/0000000c", im_we, im_addr, im_wdata); end
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 12'd2) begin errors++; $display("FAIL basic_done got done=%b hold=%b rdy=%b n=%0d exp 1/0/0/2", done, cpu_hold, in_ready, words_loaded); end
        send_byte(8'h99);
        checks++; if (im_we !== 1'b0 || (we_count - base) !== 2) begin errors++; $display("FAIL basic_we_count got we=%b cnt=%0d exp 0/2", im_we, we_count - base); end
        pulse_restart();
        checks++; if (in_ready !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 12'd0) begin errors++; $display("FAIL basic_restart got rdy=%b done=%b hold=%b n=%0d exp 1/0/1/0", in_ready, done, cpu_hold, words_loaded); end
    endtask

    task automatic test_zero_header();
        int base;
        base = we_count;
        send_word(32'h0000_0000);
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 12'd0) begin errors++; $display("FAIL zero_done got done=%b hold=%b rdy=%b n=%0d exp 1/0/0/0", done, cpu_hold, in_ready, words_loaded); end
        @(negedge clk);
        checks++; if (we_count !== base) begin errors++; $display("FAIL zero_no_we got %0d exp %0d", we_count, base); end
        pulse_restart();
        checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL zero_restart got done=%b rdy=%b exp 0/1", done, in_ready); end
    endtask

    task automatic test_err();
        logic [31:0] hdrs [2];
        hdrs[0] = 32'h0000_0801;
        hdrs[1] = 32'h0001_0000;
        for (int k = 0; k < 2; k++) begin
            send_word(hdrs[k]);
            checks++; if (err !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL err_%0d got err=%b rdy=%b hold=%b done=%b exp 1/0/1/0", k, err, in_ready, cpu_hold, done); end
            in_valid = 1'b1; in_data = 8'h00;
            repeat (3) @(negedge clk);
            in_valid = 1'b0;
            checks++; if (err !== 1'b1 || im_we !== 1'b0) begin errors++; $display("FAIL err_hold_%0d got err=%b we=%b exp 1/0", k, err, im_we); end
            pulse_restart();
            checks++; if (err !== 1'b0 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL err_restart_%0d got err=%b rdy=%b hold=%b exp 0/1/1", k, err, in_ready, cpu_hold); end
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        send_word(32'h0000_0001);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            in_data  = 8'h55;
            @(negedge clk);
            // restart outside DONE/ERR must be ignored
            if (i == 1) pulse_restart();
            send_byte(w[31-8*i -: 8]);
            if (i < 3) begin
                checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL gaps_early_we_%0d got %b exp 0", i, im_we); end
            end
        end
        checks++; if (im_we !== 1'b1 || im_addr !== 11'd0 || im_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL gaps_write got we=%b a=%h d=%h exp 1/000/deadbeef", im_we, im_addr, im_wdata); end
        checks++; if (done !== 1'b1 || words_loaded !== 12'd1) begin errors++; $display("FAIL gaps_done got done=%b n=%0d exp 1/1", done, words_loaded); end
        pulse_restart();
    endtask

    task automatic test_reset_midframe();
        send_word(32'h0000_0002);
        send_word(32'h1122_3344);
        send_byte(8'h55);
        send_byte(8'h66);
        #2 reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || words_loaded !== 12'd0 || im_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset got rdy=%b hold=%b n=%0d we=%b done=%b exp 1/1/0/0/0", in_ready, cpu_hold, words_loaded, im_we, done); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_word(32'h0000_0002);
        send_word(32'hAABB_CCDD);
        checks++; if (im_we !== 1'b1 || im_addr !== 11'd0 || im_wdata !== 32'hAABB_CCDD || done !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_w0 got we=%b a=%h d=%h done=%b hold=%b exp 1/000/aabbccdd/0/1", im_we, im_addr, im_wdata, done, cpu_hold); end
        send_word(32'h0102_0304);
        checks++; if (im_we !== 1'b1 || im_addr !== 11'd1 || im_wdata !== 32'h0102_0304 || done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL mid_w1 got we=%b a=%h d=%h done=%b hold=%b exp 1/001/01020304/1/0", im_we, im_addr, im_wdata, done, cpu_hold); end
        pulse_restart();
    endtask

    task automatic test_full_depth();
        int bad;
        bad = 0;
        send_word(32'h0000_0800);
        checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL full_hdr got err=%b rdy=%b exp 0/1", err, in_ready); end
        for (int i = 0; i < 2048; i++) begin
            send_word({16'hC0DE, 16'(i)});
            if (im_we !== 1'b1 || im_addr !== 11'(i) || im_wdata !== {16'hC0DE, 16'(i)}) bad++;
            if (i < 2047 && done !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_writes got %0d bad words exp 0", bad); end
        checks++; if (im_addr !== 11'h7FF || done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 12'h800) begin errors++; $display("FAIL full_last got a=%h done=%b hold=%b n=%h exp 7ff/1/0/800", im_addr, done, cpu_hold, words_loaded); end
        pulse_restart();
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_header();
        test_err();
        test_gaps();
        test_reset_midframe();
        test_full_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction-fetch unit. Accepts a byte stream carrying a program image and assembles it into 32-bit words.
- Writes the words into the write port of the instruction memory, word 0 corresponding to PC 0x0000_3000.
- Holds the CPU core in reset until the image is fully loaded.

Parameters:
- DEPTH_LOG2, 11, log2 of instruction-memory depth in words (2048 words).
- CNT_W, 12, width of word counters; must be at least DEPTH_LOG2+1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- restart  input  1  single-cycle pulse; re-arms loader from DONE/ERR.
- im_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- im_addr  output  DEPTH_LOG2  word index (equals (PC-0x3000)>>2).
- im_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  1 = keep core in reset.
- done  output  1  image loaded successfully.
- err  output  1  header word count exceeded memory depth.
- words_loaded  output  CNT_W  number of words written so far.

Behaviour:
- Reset (reset=0, async): state IDLE, byte_cnt=0, word_idx=0, word_total=0, shift register=0; outputs in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, err=0, words_loaded=0. Instruction-memory contents are not touched.
- Handshake: a byte transfers when in_valid & in_ready on a rising edge. in_ready = 1 in IDLE/HDR/DATA, 0 in DONE/ERR. in_data is ignored when not transferred.
- Byte order: big-endian. The first byte of each 4-byte group goes to bits [31:24]; bytes shift left 8 per transfer.
- Frame: 4-byte header N (word count), then N instruction words of 4 bytes each.
- States:
  - IDLE: first transferred byte is header byte 0 -> HDR, byte_cnt=1.
  - HDR: on the 4th header byte, latch N.
    - N==0 -> DONE.
    - N > 2**DEPTH_LOG2 -> ERR.
    - otherwise -> DATA.
    - byte_cnt wraps to 0 on the 4th byte.
  - DATA: on each 4th byte, the next cycle drives im_we=1, im_addr=word_idx, im_wdata=assembled word (registered, latency exactly 1 cycle after the 4th byte's edge). word_idx and words_loaded increment with the write. When the written word is word N-1 -> DONE, entered in the same cycle im_we is high.
  - DONE: cpu_hold=0, done=1. restart -> IDLE with counters cleared, cpu_hold=1, done=0.
  - ERR: err=1, cpu_hold=1. restart -> IDLE with counters cleared and err=0.
- restart in IDLE/HDR/DATA: ignored.
- Back-to-back bytes (in_valid held 1) must be accepted every cycle with no stall. A write pulse and the next word's first byte can occur in the same cycle.
- N == 2**DEPTH_LOG2 is legal: the last write is at im_addr = all ones, and word_idx does not wrap before DONE.
- Reset asserted mid-frame: immediate return to reset values. A partially written image is not invalidated; the core stays held until a full reload completes.
- Counters use CNT_W bits. Comparisons against N use the full CNT_W width; the compare value is never truncated to DEPTH_LOG2.

Decomposition:
- Shared package: state encoding (IDLE, HDR, DATA, DONE, ERR), IM_BASE = 32'h0000_3000, header byte count = 4.
- One natural sub-module: imem_loader_assembler. It holds the 8-to-32 shift register and the 2-bit byte counter, and emits a word_valid pulse plus the word. The FSM and the write port stay in imem_loader.

Test Plan:
- Reset release, no input -> in_ready=1, cpu_hold=1, done=0, err=0, im_we never asserted.
- Stream 00 00 00 02, 34 08 00 05, 00 00 00 0C, valid every cycle -> im_we twice: (addr 0, 0x34080005) and (addr 1, 0x0000000C). done=1 and cpu_hold=0 from the second write cycle; in_ready=0 afterwards.
- Header 00 00 00 00 -> DONE directly after 4th byte, no im_we, words_loaded=0.
- Header 00 00 08 01 (2049 > 2048) -> err=1, in_ready=0, cpu_hold=1. restart pulse -> IDLE, err=0.
- One word with gaps (in_valid toggled 1/0) -> single write of correct word 1 cycle after 4th accepted byte. Bytes offered with in_valid=0 are not consumed.
- Reset pulse after 6 data bytes of a 2-word image, then full valid reload -> words at addr 0 and 1 rewritten correctly, done=1 only after reload.
